vga_sync_gen: RTL and testbench

Free-running VGA timing generator: the transmit end of the sync interface consumed by the pong top level's sync-to-count stage. It produces active-region HSync/VSync levels that the game pipeline consumes. It also produces porch-shaped VGA sync pulses for the connector, plus the column/row counts and a frame-start strobe. It sits between the board clock/reset and the game logic.

---
 rtl/vga_sync_gen_if.sv | 33 +++
 rtl/vga_sync_gen.sv | 99 +++++++++
 tb/tb_vga_sync_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Sync bundle from the VGA timing generator to the game pipeline and the connector.
interface vga_sync_gen_if;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       vga_hsync;
    logic       vga_vsync;
    logic [9:0] col_count;
    logic [9:0] row_count;
    logic       frame_start;

    modport master (
        output hsync,
        output vsync,
        output active,
        output vga_hsync,
        output vga_vsync,
        output col_count,
        output row_count,
        output frame_start
    );

    modport slave (
        input hsync,
        input vsync,
        input active,
        input vga_hsync,
        input vga_vsync,
        input col_count,
        input row_count,
        input frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator. The column/row counters and every decode are
// registered from the same next-count values, so all outputs describe the same pixel.
module vga_sync_gen #(
    parameter int unsigned TOTAL_COLS      = 800,
    parameter int unsigned TOTAL_ROWS      = 525,
    parameter int unsigned ACTIVE_COLS     = 640,
    parameter int unsigned ACTIVE_ROWS     = 480,
    parameter int unsigned H_FRONT_PORCH   = 16,
    parameter int unsigned H_SYNC_WIDTH    = 96,
    parameter int unsigned V_FRONT_PORCH   = 10,
    parameter int unsigned V_SYNC_WIDTH    = 2,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    vga_sync_gen_if.master sync
);

    localparam logic [9:0] LastCol     = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] LastRow     = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ActiveCols  = 10'(ACTIVE_COLS);
    localparam logic [9:0] ActiveRows  = 10'(ACTIVE_ROWS);
    localparam logic [9:0] HPulseFirst = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] HPulseLast  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
    localparam logic [9:0] VPulseFirst = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] VPulseLast  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       col_wrap;
    logic       frame_wrap;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       active_q, active_d;
    logic       vga_hsync_q, vga_hsync_d;
    logic       vga_vsync_q, vga_vsync_d;
    logic       frame_start_q, frame_start_d;

    logic       h_pulse;
    logic       v_pulse;

    // Next-count logic: column always advances, row advances only on a column wrap.
    always_comb begin
        col_wrap   = (col_q == LastCol);
        frame_wrap = col_wrap && (row_q == LastRow);
        col_d      = col_wrap ? 10'd0 : col_q + 10'd1;
        row_d      = row_q;
        if (col_wrap) begin
            row_d = (row_q == LastRow) ? 10'd0 : row_q + 10'd1;
        end
    end

    // Decode sync levels and porch-shaped pulses from the next counts.
    always_comb begin
        hsync_d       = (col_d < ActiveCols);
        vsync_d       = (row_d < ActiveRows);
        active_d      = hsync_d && vsync_d;
        // VSync pulse is a pure row decode, deliberately not aligned to the HSync pulse.
        h_pulse       = (col_d >= HPulseFirst) && (col_d <= HPulseLast);
        v_pulse       = (row_d >= VPulseFirst) && (row_d <= VPulseLast);
        vga_hsync_d   = h_pulse ^ SYNC_ACTIVE_LOW;
        vga_vsync_d   = v_pulse ^ SYNC_ACTIVE_LOW;
        frame_start_d = frame_wrap;
    end

    // State and output registers; reset lands on (0,0) without a frame-start strobe.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b1;
            vga_hsync_q   <= SYNC_ACTIVE_LOW;
            vga_vsync_q   <= SYNC_ACTIVE_LOW;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            vga_hsync_q   <= vga_hsync_d;
            vga_vsync_q   <= vga_vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sync.col_count   = col_q;
    assign sync.row_count   = row_q;
    assign sync.hsync       = hsync_q;
    assign sync.vsync       = vsync_q;
    assign sync.active      = active_q;
    assign sync.vga_hsync   = vga_hsync_q;
    assign sync.vga_vsync   = vga_vsync_q;
    assign sync.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two small-geometry instances (both sync polarities) for full-frame
// behaviour and one default-geometry instance for the horizontal timing.
module tb_vga_sync_gen;

    // Small geometry: HSync pulse cols 14..16, VSync pulse rows 9..10, frame = 240 cycles.
    localparam int unsigned TC = 20;
    localparam int unsigned TR = 12;
    localparam int unsigned AC = 12;
    localparam int unsigned AR = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HW = 3;
    localparam int unsigned VF = 1;
    localparam int unsigned VW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_gen_if s_low ();
    vga_sync_gen_if s_high ();
    vga_sync_gen_if s_def ();

    vga_sync_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HF), .H_SYNC_WIDTH(HW), .V_FRONT_PORCH(VF), .V_SYNC_WIDTH(VW),
        .SYNC_ACTIVE_LOW(1'b1)
    ) u_dut_low (
        .i_Clk(clk), .i_Reset(rst), .sync(s_low)
    );

    vga_sync_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HF), .H_SYNC_WIDTH(HW), .V_FRONT_PORCH(VF), .V_SYNC_WIDTH(VW),
        .SYNC_ACTIVE_LOW(1'b0)
    ) u_dut_high (
        .i_Clk(clk), .i_Reset(rst), .sync(s_high)
    );

    vga_sync_gen u_dut_def (
        .i_Clk(clk), .i_Reset(rst), .sync(s_def)
    );

    // Packed view: {6'b0, frame_start, vga_vsync, vga_hsync, active, vsync, hsync, row, col}
    logic [31:0] obs_low, obs_high, obs_def;
    assign obs_low  = {6'd0, s_low.frame_start, s_low.vga_vsync, s_low.vga_hsync,
                       s_low.active, s_low.vsync, s_low.hsync, s_low.row_count, s_low.col_count};
    assign obs_high = {6'd0, s_high.frame_start, s_high.vga_vsync, s_high.vga_hsync,
                       s_high.active, s_high.vsync, s_high.hsync, s_high.row_count,
                       s_high.col_count};
    assign obs_def  = {6'd0, s_def.frame_start, s_def.vga_vsync, s_def.vga_hsync,
                       s_def.active, s_def.vsync, s_def.hsync, s_def.row_count, s_def.col_count};

    // Reset state: counts 0, levels 1, pulses deasserted, no strobe.
    localparam logic [31:0] RstLow  = {6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
    localparam logic [31:0] RstHigh = {6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_cyc    = 0;
    int unsigned fs_count = 0;
    int unsigned first_fs = 0;
    int unsigned vlow_cnt = 0;
    int unsigned vhigh_cnt = 0;
    int unsigned hlow_def = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", tag, n_cyc, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs n cycles after reset release, straight from the timing definition.
    function automatic logic [31:0] model(input int unsigned n, tc, tr, ac, ar, hf, hw, vf, vw,
                                          input bit low);
        int unsigned col, row;
        bit hs, vs, hp, vp, fs;
        col = n % tc;
        row = (n / tc) % tr;
        hs  = (col < ac);
        vs  = (row < ar);
        hp  = (col >= ac + hf) && (col < ac + hf + hw);
        vp  = (row >= ar + vf) && (row < ar + vf + vw);
        fs  = (n != 0) && (col == 0) && (row == 0);
        return {6'd0, fs, vp ^ low, hp ^ low, hs & vs, vs, hs, row[9:0], col[9:0]};
    endfunction

    // Compare all instances at cycle n_cyc, plus directed default-geometry points.
    task automatic scan_check();
        check("low_all", obs_low, model(n_cyc, TC, TR, AC, AR, HF, HW, VF, VW, 1'b1));
        check("high_all", obs_high, model(n_cyc, TC, TR, AC, AR, HF, HW, VF, VW, 1'b0));
        check("def_all", obs_def, model(n_cyc, 800, 525, 640, 480, 16, 96, 10, 2, 1'b1));
        if (s_low.frame_start) begin
            if (fs_count == 0) first_fs = n_cyc;
            fs_count++;
        end
        if (n_cyc < TC * TR && !s_low.vga_vsync) vlow_cnt++;
        if (n_cyc < TC * TR && s_high.vga_vsync) vhigh_cnt++;
        if (n_cyc < 800 && !s_def.vga_hsync) hlow_def++;
        if (n_cyc == 639) check("def_hsync_639", 32'(s_def.hsync), 32'd1);
        if (n_cyc == 640) check("def_hsync_640", 32'(s_def.hsync), 32'd0);
        if (n_cyc == 655) check("def_vgah_655", 32'(s_def.vga_hsync), 32'd1);
        if (n_cyc == 656) check("def_vgah_656", 32'(s_def.vga_hsync), 32'd0);
        if (n_cyc == 751) check("def_vgah_751", 32'(s_def.vga_hsync), 32'd0);
        if (n_cyc == 752) check("def_vgah_752", 32'(s_def.vga_hsync), 32'd1);
        if (n_cyc == 799) check("def_rc_799", {12'd0, s_def.row_count, s_def.col_count},
                                {12'd0, 10'd0, 10'd799});
        if (n_cyc == 800) check("def_rc_800", {12'd0, s_def.row_count, s_def.col_count},
                                {12'd0, 10'd1, 10'd0});
        if (n_cyc == 800) check("def_hsync_800", 32'(s_def.hsync), 32'd1);
        if (n_cyc == 240) check("low_fs_240", 32'(s_low.frame_start), 32'd1);
        if (n_cyc == 241) check("low_fs_241", 32'(s_low.frame_start), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (7) step();
        check("pre_reset_col", 32'(s_low.col_count), 32'd7);

        // Reset held for 5 cycles mid-line.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_low", obs_low, RstLow);
            check("rst_high", obs_high, RstHigh);
            check("rst_def", obs_def, RstLow);
        end
        rst = 1'b0;
        n_cyc = 0;
        scan_check();
        for (int i = 0; i < 1700; i++) begin
            step();
            n_cyc++;
            if (n_cyc == 1) check("rel_col1", 32'(s_low.col_count), 32'd1);
            scan_check();
        end
        check("fs_first", first_fs, 32'd240);
        check("fs_count", fs_count, 32'd7);
        check("vga_vsync_low_len", vlow_cnt, 32'd40);
        check("vga_vsync_high_len", vhigh_cnt, 32'd40);
        check("def_vga_hsync_low_len", hlow_def, 32'd96);

        // Mid-frame reset at (15,5).
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cyc = 0;
        repeat (115) step();
        check("mid_pos", {12'd0, s_low.row_count, s_low.col_count}, {12'd0, 10'd5, 10'd15});
        rst = 1'b1;
        step();
        check("mid_rst_low", obs_low, RstLow);
        check("mid_rst_high", obs_high, RstHigh);
        rst = 1'b0;
        n_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            n_cyc++;
            scan_check();
        end

        // Reset on the last pixel of the frame must not produce a frame-start strobe.
        repeat (239 - 30) step();
        n_cyc = 239;
        check("last_pos", {12'd0, s_low.row_count, s_low.col_count}, {12'd0, 10'd11, 10'd19});
        rst = 1'b1;
        step();
        check("wrap_rst_low", obs_low, RstLow);
        check("wrap_rst_high", obs_high, RstHigh);
        rst = 1'b0;
        n_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            n_cyc++;
            scan_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
